// File: rtl/vmicro16_apb_rr_arbiter_pkg.sv
// Shared definitions for the vmicro16 APB round-robin arbiter:
// FSM state encoding, bus geometry and slave select indices.
package vmicro16_apb_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ERR    = 2'd3
    } apb_state_e;

    localparam int APB_WIDTH  = 16;
    localparam int APB_SLAVES = 8;

    localparam int APB_PSELX_GPIO0 = 0;
    localparam int APB_PSELX_GPIO1 = 1;
    localparam int APB_PSELX_GPIO2 = 2;
    localparam int APB_PSELX_UART0 = 3;
    localparam int APB_PSELX_REGS0 = 4;
    localparam int APB_PSELX_BRAM0 = 5;

    // Index width that stays legal (>=1 bit) even for single-entry vectors.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vmicro16_rr_pick.sv
// Rotating-priority encoder: returns the first set request bit found when
// scanning from ptr_i upwards, wrapping modulo N.
module vmicro16_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         valid_o,
    output logic [W-1:0] idx_o
);

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = 0; i < N; i++) begin
            if (!valid_o && req_i[(int'(ptr_i) + i) % N]) begin
                valid_o = 1'b1;
                idx_o   = W'((int'(ptr_i) + i) % N);
            end
        end
    end

endmodule

// File: rtl/vmicro16_apb_rr_arbiter.sv
// Shares one APB slave bus between several core master ports: round-robin
// grant, one-hot slave decode, SETUP/ACCESS sequencing, decode-error and timeout.
module vmicro16_apb_rr_arbiter
    import vmicro16_apb_rr_arbiter_pkg::*;
#(
    parameter int MASTER_PORTS = 4,
    parameter int SLAVE_PORTS  = APB_SLAVES,
    parameter int BUS_WIDTH    = APB_WIDTH,
    parameter int SEL_LSB      = 8,
    parameter int TIMEOUT      = 255,
    localparam int MW          = clog2_min1(MASTER_PORTS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PADDR,
    input  logic [MASTER_PORTS-1:0]           S_PWRITE,
    input  logic [MASTER_PORTS-1:0]           S_PSELx,
    input  logic [MASTER_PORTS-1:0]           S_PENABLE,
    input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PWDATA,
    output logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PRDATA,
    output logic [MASTER_PORTS-1:0]           S_PREADY,
    output logic [MASTER_PORTS-1:0]           S_PSLVERR,
    output logic [BUS_WIDTH-1:0]              M_PADDR,
    output logic                              M_PWRITE,
    output logic [SLAVE_PORTS-1:0]            M_PSELx,
    output logic                              M_PENABLE,
    output logic [BUS_WIDTH-1:0]              M_PWDATA,
    input  logic [SLAVE_PORTS*BUS_WIDTH-1:0]  M_PRDATA,
    input  logic [SLAVE_PORTS-1:0]            M_PREADY,
    output logic [MW-1:0]                     grant_id,
    output logic                              busy
);

    localparam int SW = clog2_min1(SLAVE_PORTS);
    localparam int TW = clog2_min1(TIMEOUT + 1);
    localparam int DW = BUS_WIDTH - SEL_LSB;
    localparam logic [MW-1:0] LAST_MASTER = MW'(MASTER_PORTS - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    apb_state_e     state_q, state_d;
    logic [MW-1:0]  grant_q, grant_d;
    logic [MW-1:0]  rrPtr_q, rrPtr_d;
    logic [SW-1:0]  idx_q, idx_d;
    logic [TW-1:0]  tmoCnt_q, tmoCnt_d;

    logic           pickValid;
    logic [MW-1:0]  pickIdx;
    logic [DW-1:0]  decField;
    logic           decOk;

    logic [BUS_WIDTH-1:0] gntAddr;
    logic [BUS_WIDTH-1:0] gntWdata;
    logic                 gntWrite;
    logic [BUS_WIDTH-1:0] slvRdata;
    logic                 slvReady;

    logic unusedPenable;
    assign unusedPenable = ^S_PENABLE;

    vmicro16_rr_pick #(
        .N (MASTER_PORTS),
        .W (MW)
    ) u_pick (
        .req_i   (S_PSELx),
        .ptr_i   (rrPtr_q),
        .valid_o (pickValid),
        .idx_o   (pickIdx)
    );

    // The whole field above SEL_LSB is decoded so that out-of-range slave
    // numbers raise a decode error instead of aliasing onto a real slave.
    assign decField = S_PADDR[pickIdx*BUS_WIDTH + SEL_LSB +: DW];
    assign decOk    = (int'(decField) < SLAVE_PORTS);

    assign gntAddr  = S_PADDR[grant_q*BUS_WIDTH +: BUS_WIDTH];
    assign gntWdata = S_PWDATA[grant_q*BUS_WIDTH +: BUS_WIDTH];
    assign gntWrite = S_PWRITE[grant_q];
    assign slvRdata = M_PRDATA[idx_q*BUS_WIDTH +: BUS_WIDTH];
    assign slvReady = M_PREADY[idx_q];

    assign grant_id = grant_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rrPtr_q  <= '0;
            idx_q    <= '0;
            tmoCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rrPtr_q  <= rrPtr_d;
            idx_q    <= idx_d;
            tmoCnt_q <= tmoCnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rrPtr_d  = rrPtr_q;
        idx_d    = idx_q;
        tmoCnt_d = tmoCnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pickValid) begin
                    grant_d = pickIdx;
                    rrPtr_d = (pickIdx == LAST_MASTER) ? '0 : pickIdx + 1'b1;
                    idx_d   = SW'(decField);
                    if (decOk) begin
                        state_d  = ST_SETUP;
                        tmoCnt_d = '0;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                // Saturate so a disabled timeout never wraps the counter.
                if (tmoCnt_q != '1) begin
                    tmoCnt_d = tmoCnt_q + 1'b1;
                end
                if (slvReady) begin
                    state_d = ST_IDLE;
                end else if (TIMEOUT != 0 && tmoCnt_q == TMO_LAST) begin
                    state_d = ST_ERR;
                end
            end
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        M_PADDR   = '0;
        M_PWRITE  = 1'b0;
        M_PWDATA  = '0;
        M_PSELx   = '0;
        M_PENABLE = 1'b0;
        S_PRDATA  = '0;
        S_PREADY  = '0;
        S_PSLVERR = '0;
        busy      = (state_q != ST_IDLE);
        unique case (state_q)
            ST_SETUP, ST_ACCESS: begin
                M_PSELx[idx_q] = 1'b1;
                M_PADDR        = gntAddr;
                M_PWRITE       = gntWrite;
                M_PWDATA       = gntWdata;
                if (state_q == ST_ACCESS) begin
                    M_PENABLE = 1'b1;
                    if (slvReady) begin
                        S_PREADY[grant_q]                        = 1'b1;
                        S_PRDATA[grant_q*BUS_WIDTH +: BUS_WIDTH] = slvRdata;
                    end
                end
            end
            ST_ERR: begin
                S_PREADY[grant_q]  = 1'b1;
                S_PSLVERR[grant_q] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vmicro16_apb_rr_arbiter.sv
// Self-checking bench for vmicro16_apb_rr_arbiter: directed scenarios plus
// randomized traffic compared every cycle against a transfer-level model.
module tb_vmicro16_apb_rr_arbiter;
    import vmicro16_apb_rr_arbiter_pkg::*;

    localparam int M   = 4;
    localparam int S   = 8;
    localparam int BW  = 16;
    localparam int SEL = 8;
    localparam int TMO = 4;
    localparam int MW  = 2;

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic [M*BW-1:0] S_PADDR, S_PWDATA, S_PRDATA;
    logic [M-1:0]    S_PWRITE, S_PSELx, S_PENABLE, S_PREADY, S_PSLVERR;
    logic [BW-1:0]   M_PADDR, M_PWDATA;
    logic            M_PWRITE, M_PENABLE;
    logic [S-1:0]    M_PSELx, M_PREADY;
    logic [S*BW-1:0] M_PRDATA;
    logic [MW-1:0]   grant_id;
    logic            busy;

    vmicro16_apb_rr_arbiter #(
        .MASTER_PORTS (M),
        .SLAVE_PORTS  (S),
        .BUS_WIDTH    (BW),
        .SEL_LSB      (SEL),
        .TIMEOUT      (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .S_PADDR   (S_PADDR),
        .S_PWRITE  (S_PWRITE),
        .S_PSELx   (S_PSELx),
        .S_PENABLE (S_PENABLE),
        .S_PWDATA  (S_PWDATA),
        .S_PRDATA  (S_PRDATA),
        .S_PREADY  (S_PREADY),
        .S_PSLVERR (S_PSLVERR),
        .M_PADDR   (M_PADDR),
        .M_PWRITE  (M_PWRITE),
        .M_PSELx   (M_PSELx),
        .M_PENABLE (M_PENABLE),
        .M_PWDATA  (M_PWDATA),
        .M_PRDATA  (M_PRDATA),
        .M_PREADY  (M_PREADY),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Master and slave stimulus state.
    bit            reqA   [M];
    logic [BW-1:0] addrA  [M];
    logic [BW-1:0] wdataA [M];
    bit            writeA [M];
    logic [S-1:0]  slvReady;
    logic [BW-1:0] slvData [S];
    bit            dropGranted;

    // Transfer-level model: k counts cycles since the grant edge (1 = first).
    bit busyM;
    bit decErr;
    int curM, curIdx, k, ptr, lastGrant;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic modelReset();
        busyM     = 1'b0;
        ptr       = 0;
        lastGrant = 0;
        k         = 0;
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < M; i++) begin
            S_PADDR[i*BW +: BW]  = addrA[i];
            S_PWDATA[i*BW +: BW] = wdataA[i];
            S_PWRITE[i]          = writeA[i];
            S_PSELx[i]           = reqA[i] && !(dropGranted && busyM && i == curM);
            S_PENABLE[i]         = 1'($urandom_range(0, 1));
        end
        for (int s = 0; s < S; s++) M_PRDATA[s*BW +: BW] = slvData[s];
        M_PREADY = slvReady;
        #1;
    endtask

    task automatic checkOutput();
        logic [M*BW-1:0] eRdata;
        logic [M-1:0]    eReady, eErr;
        logic [BW-1:0]   eAddr, eWdata;
        logic            eWrite, eEnable;
        logic [S-1:0]    eSel;
        eRdata = '0; eReady = '0; eErr = '0; eAddr = '0; eWdata = '0;
        eWrite = 1'b0; eEnable = 1'b0; eSel = '0;
        if (busyM) begin
            if (decErr || k == TMO + 2) begin
                eReady[curM] = 1'b1;
                eErr[curM]   = 1'b1;
            end else begin
                eSel[curIdx] = 1'b1;
                eAddr  = addrA[curM];
                eWdata = wdataA[curM];
                eWrite = writeA[curM];
                if (k >= 2) begin
                    eEnable = 1'b1;
                    if (slvReady[curIdx]) begin
                        eReady[curM]           = 1'b1;
                        eRdata[curM*BW +: BW]  = slvData[curIdx];
                    end
                end
            end
        end
        chk("S_PRDATA",  64'(S_PRDATA),  64'(eRdata));
        chk("S_PREADY",  64'(S_PREADY),  64'(eReady));
        chk("S_PSLVERR", 64'(S_PSLVERR), 64'(eErr));
        chk("M_PADDR",   64'(M_PADDR),   64'(eAddr));
        chk("M_PWDATA",  64'(M_PWDATA),  64'(eWdata));
        chk("M_PWRITE",  64'(M_PWRITE),  64'(eWrite));
        chk("M_PSELx",   64'(M_PSELx),   64'(eSel));
        chk("M_PENABLE", 64'(M_PENABLE), 64'(eEnable));
        chk("grant_id",  64'(grant_id),  64'(lastGrant));
        chk("busy",      64'(busy),      64'(busyM));
        // Advance the model across the coming rising edge.
        if (busyM) begin
            if (eReady != '0) begin
                busyM      = 1'b0;
                reqA[curM] = 1'b0;
            end else begin
                k++;
            end
        end else begin
            for (int j = 0; j < M; j++) begin
                int c;
                c = (ptr + j) % M;
                if (!busyM && S_PSELx[c]) begin
                    busyM     = 1'b1;
                    curM      = c;
                    lastGrant = c;
                    ptr       = (c + 1) % M;
                    curIdx    = int'(addrA[c][BW-1:SEL]);
                    decErr    = (curIdx >= S);
                    k         = 1;
                end
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < M; i++) reqA[i] = 1'b0;
        slvReady    = '1;
        dropGranted = 1'b0;
        for (int n = 0; n < 20 && busyM; n++) begin
            applyStimulus();
            checkOutput();
        end
        if (busyM) begin
            miscompares++;
            $display("[TB] FAIL drain: transfer still open after 20 cycles");
        end
    endtask

    initial begin
        int expOrder [5] = '{0, 1, 2, 3, 0};
        int grantQ [$];
        int accCnt;
        bit errSeen;

        for (int i = 0; i < M; i++) begin
            reqA[i] = 1'b0; addrA[i] = '0; wdataA[i] = '0; writeA[i] = 1'b0;
        end
        for (int s = 0; s < S; s++) slvData[s] = 16'($urandom);
        slvReady = '0; dropGranted = 1'b0;
        S_PADDR = '0; S_PWDATA = '0; S_PWRITE = '0; S_PSELx = '0; S_PENABLE = '0;
        M_PRDATA = '0; M_PREADY = '0;
        reset = 1'b0;
        modelReset();

        #7;
        chk("rst_busy",   64'(busy),      64'h0);
        chk("rst_grant",  64'(grant_id),  64'h0);
        chk("rst_psel",   64'(M_PSELx),   64'h0);
        chk("rst_pready", 64'(S_PREADY),  64'h0);
        chk("rst_penab",  64'(M_PENABLE), 64'h0);
        chk("rst_paddr",  64'(M_PADDR),   64'h0);

        // Single read from master 0 to UART0 with a zero-wait slave.
        reqA[0] = 1'b1; addrA[0] = 16'h0305; writeA[0] = 1'b0;
        slvReady = '1; slvData[APB_PSELX_UART0] = 16'hA5C3;
        applyStimulus(); checkOutput();
        applyStimulus();
        chk("t1_setup_psel",  64'(M_PSELx),   64'h08);
        chk("t1_setup_penab", 64'(M_PENABLE), 64'h0);
        chk("t1_setup_ready", 64'(S_PREADY),  64'h0);
        checkOutput();
        applyStimulus();
        chk("t1_pready", 64'(S_PREADY),       64'h1);
        chk("t1_prdata", 64'(S_PRDATA[15:0]), 64'hA5C3);
        checkOutput();

        // All masters request continuously from reset.
        #2 reset = 1'b0;
        #1 modelReset();
        for (int i = 0; i < M; i++) begin
            reqA[i] = 1'b1; addrA[i] = 16'(i * 256 + 16'h10); wdataA[i] = 16'(i);
        end
        for (int n = 0; n < 40 && grantQ.size() < 5; n++) begin
            applyStimulus();
            if (busy && (M_PSELx != '0) && !M_PENABLE) grantQ.push_back(int'(grant_id));
            checkOutput();
            for (int i = 0; i < M; i++) reqA[i] = 1'b1;
        end
        chk("t2_grants", 64'(grantQ.size()), 64'd5);
        for (int n = 0; n < grantQ.size() && n < 5; n++)
            chk("t2_order", 64'(grantQ[n]), 64'(expOrder[n]));
        drain();

        // Decode error from master 2.
        reqA[2] = 1'b1; addrA[2] = 16'h0900;
        applyStimulus(); checkOutput();
        applyStimulus();
        chk("t3_psel",   64'(M_PSELx),   64'h0);
        chk("t3_pready", 64'(S_PREADY),  64'h4);
        chk("t3_slverr", 64'(S_PSLVERR), 64'h4);
        chk("t3_prdata", 64'(S_PRDATA),  64'h0);
        checkOutput();
        drain();

        // Timeout on a stalled slave, with master 3 queued behind it.
        slvReady = '0;
        reqA[1] = 1'b1; addrA[1] = 16'h0210;
        applyStimulus(); checkOutput();
        reqA[3] = 1'b1; addrA[3] = 16'h0305;
        accCnt = 0; errSeen = 1'b0;
        for (int n = 0; n < 20 && !errSeen; n++) begin
            applyStimulus();
            if (M_PENABLE) accCnt++;
            if (S_PSLVERR[1]) errSeen = 1'b1;
            checkOutput();
        end
        chk("t4_access_cycles", 64'(accCnt),  64'd4);
        chk("t4_err_seen",      64'(errSeen), 64'd1);
        applyStimulus();
        chk("t4_idle", 64'(busy), 64'h0);
        checkOutput();
        applyStimulus();
        chk("t4_next_grant", 64'(grant_id), 64'd3);
        checkOutput();
        drain();

        // Reset asserted in the middle of an ACCESS phase.
        slvReady = '0;
        reqA[0] = 1'b1; addrA[0] = 16'h0400;
        applyStimulus(); checkOutput();
        applyStimulus(); checkOutput();
        applyStimulus();
        chk("t5_in_access", 64'(M_PENABLE), 64'h1);
        checkOutput();
        reqA[2] = 1'b1; addrA[2] = 16'h0500;
        #2 reset = 1'b0;
        #1;
        chk("t5_busy",   64'(busy),      64'h0);
        chk("t5_grant",  64'(grant_id),  64'h0);
        chk("t5_psel",   64'(M_PSELx),   64'h0);
        chk("t5_penab",  64'(M_PENABLE), 64'h0);
        chk("t5_paddr",  64'(M_PADDR),   64'h0);
        chk("t5_pready", 64'(S_PREADY),  64'h0);
        chk("t5_slverr", 64'(S_PSLVERR), 64'h0);
        chk("t5_prdata", 64'(S_PRDATA),  64'h0);
        modelReset();
        slvReady = '1;
        applyStimulus(); checkOutput();
        applyStimulus();
        chk("t5_first_grant", 64'(grant_id), 64'd0);
        checkOutput();
        drain();

        // Write with three wait states from master 3 to GPIO1.
        reqA[3] = 1'b1; addrA[3] = 16'h0140; wdataA[3] = 16'hBEEF; writeA[3] = 1'b1;
        accCnt = 0;
        for (int n = 0; n < 6; n++) begin
            slvReady = '0;
            slvReady[1] = busyM && (curM == 3) && (k == 5);
            applyStimulus();
            if (M_PENABLE) begin
                accCnt++;
                chk("t6_pwdata", 64'(M_PWDATA), 64'hBEEF);
                chk("t6_paddr",  64'(M_PADDR),  64'h0140);
                chk("t6_pwrite", 64'(M_PWRITE), 64'h1);
                chk("t6_pready", 64'(S_PREADY), (accCnt < 4) ? 64'h0 : 64'h8);
            end
            checkOutput();
        end
        chk("t6_access_cycles", 64'(accCnt), 64'd4);
        drain();

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < M; i++) begin
                if (!reqA[i] && $urandom_range(0, 3) == 0) begin
                    int idx;
                    idx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 255))
                                                      : int'($urandom_range(0, 7));
                    reqA[i]   = 1'b1;
                    addrA[i]  = {8'(idx), 8'($urandom)};
                    wdataA[i] = 16'($urandom);
                    writeA[i] = 1'($urandom_range(0, 1));
                end
            end
            for (int s = 0; s < S; s++) begin
                slvReady[s] = ($urandom_range(0, 9) < 7);
                slvData[s]  = 16'($urandom);
            end
            dropGranted = ($urandom_range(0, 7) == 0);
            applyStimulus();
            checkOutput();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
